// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for an 8-digit common-anode
// seven-segment display. Consumes the packed 8-nibble board7SD word from
// vending_machine, snapshots it once per full scan, and drives one digit
// per refresh slot with leading-zero blanking and a fixed decimal point.
//
// Timing summary:
//   - First clock after reset release: snapshot taken, frame_tick high.
//   - prescale counts 0..REFRESH_DIV-1 once scanning has started; the
//     cycle it sits at REFRESH_DIV-1 is a slot tick and digit_sel advances.
//   - A slot tick that wraps digit_sel 7 -> 0 takes a new snapshot.
//   - an/seg/dp are registered from digit_sel, so they trail it by one cycle.
module seven_seg_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter bit DP_EN       = 1'b1,
    parameter int DP_POS      = 2,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] digits_in,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [2:0]  digit_sel,
    output logic        frame_tick
);

    localparam int              PW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]   SLOT_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [2:0]      DP_DIGIT  = 3'(DP_POS);
    localparam logic [6:0]      SEG_BLANK = 7'h7F;

    // Low during the very first post-reset cycle; that cycle takes the
    // initial snapshot and keeps the anodes off so a stale snapshot is
    // never shown.
    logic          started;
    logic [PW-1:0] prescale;
    logic [31:0]   snapshot;

    logic          slotTick;
    logic          frameWrap;
    logic          takeSnapshot;
    logic [3:0]    curNibble;
    logic [7:0]    blankMask;
    logic          zerosAbove;
    logic [7:0]    anNext;
    logic [6:0]    segNext;
    logic          dpNext;

    // Active-low glyph table, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h3F;  // dash
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // Slot and frame boundaries derived from the prescaler and digit index.
    always_comb begin
        slotTick     = started && (prescale == SLOT_LAST);
        frameWrap    = slotTick && (digit_sel == 3'd7);
        takeSnapshot = !started || frameWrap;
    end

    // Prescaler: free-running slot timer, held at zero until scanning starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescale <= '0;
        end else if (started) begin
            if (slotTick) prescale <= '0;
            else          prescale <= prescale + 1'b1;
        end
    end

    // Scan state: start flag and the digit currently being driven.
    always_ff @(posedge clk) begin
        if (reset) begin
            started   <= 1'b0;
            digit_sel <= 3'd0;
        end else begin
            started <= 1'b1;
            if (slotTick) digit_sel <= digit_sel + 3'd1;
        end
    end

    // Snapshot register and its one-cycle announcement pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            snapshot   <= 32'h0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= takeSnapshot;
            if (takeSnapshot) snapshot <= digits_in;
        end
    end

    // Leading-zero mask: digit i is blanked when it lies above the decimal
    // point digit and every snapshot nibble from 7 down to i is zero.
    always_comb begin
        blankMask  = 8'h00;
        zerosAbove = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            zerosAbove = zerosAbove && (snapshot[4*i +: 4] == 4'h0);
            if (BLANK_LZ && (i > DP_POS) && zerosAbove) blankMask[i] = 1'b1;
        end
    end

    // Next display drive for the digit selected this cycle.
    always_comb begin
        curNibble = snapshot[{digit_sel, 2'b00} +: 4];
        anNext    = ~(8'b0000_0001 << digit_sel);
        segNext   = blankMask[digit_sel] ? SEG_BLANK : glyph(curNibble);
        // The decimal point is independent of blanking.
        dpNext    = !(DP_EN && (digit_sel == DP_DIGIT));
    end

    // Registered display outputs; dark until the first snapshot is in place.
    always_ff @(posedge clk) begin
        if (reset || !started) begin
            an  <= 8'hFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= anNext;
            seg <= segNext;
            dp  <= dpNext;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Testbench for seven_seg_scan with REFRESH_DIV=4, DP_EN=1, DP_POS=2,
// BLANK_LZ=1. The reference model works from the count of edges since reset
// release: slot and frame positions come from integer division, the shown
// value from the last frame-boundary sample of digits_in.
module tb_seven_seg_scan;

    localparam int DIV   = 4;
    localparam int FRAME = 8 * DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] digits_in;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [2:0]  digit_sel;
    logic        frame_tick;

    int          passed = 0;
    int          failed = 0;
    int          total  = 0;
    int          n      = 0;     // edges since reset release
    logic [31:0] curDigits;
    logic [31:0] modelSnap;

    seven_seg_scan #(
        .REFRESH_DIV(DIV),
        .DP_EN      (1'b1),
        .DP_POS     (2),
        .BLANK_LZ   (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .digits_in (digits_in),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .digit_sel (digit_sel),
        .frame_tick(frame_tick)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    function automatic logic [6:0] refGlyph(input int v);
        case (v)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  10: return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic setDigits(input logic [31:0] v);
        curDigits = v;
        digits_in = v;
    endtask

    function automatic int modelSel();
        return ((n - 1) / DIV) % 8;
    endfunction

    // Hold reset for k edges, checking reset values after each edge.
    task automatic doReset(input int k);
        reset = 1'b1;
        repeat (k) begin
            @(posedge clk);
            #1;
            check("rst_an", an, 8'hFF);
            check("rst_seg", seg, 7'h7F);
            check("rst_dp", dp, 1'b1);
            check("rst_sel", digit_sel, 3'd0);
            check("rst_ft", frame_tick, 1'b0);
        end
        reset = 1'b0;
        n = 0;
    endtask

    // One clock with the reference model advanced and all outputs compared.
    task automatic step();
        logic [7:0] expAn;
        logic [6:0] expSeg;
        logic       expDp;
        logic       expFt;
        int         d;
        int         nib;
        @(posedge clk);
        n++;
        expFt = (n == 1) || ((n - 1) % FRAME == 0);
        if (n >= 2) begin
            d      = ((n - 2) / DIV) % 8;
            expAn  = ~(8'h01 << d);
            nib    = int'((modelSnap >> (4 * d)) & 32'hF);
            if (d > 2 && (modelSnap >> (4 * d)) == 32'h0) expSeg = 7'h7F;
            else                                          expSeg = refGlyph(nib);
            expDp  = (d == 2) ? 1'b0 : 1'b1;
        end else begin
            expAn  = 8'hFF;
            expSeg = 7'h7F;
            expDp  = 1'b1;
        end
        if (expFt) modelSnap = curDigits;
        #1;
        check("an", an, expAn);
        check("seg", seg, expSeg);
        check("dp", dp, expDp);
        check("digit_sel", digit_sel, modelSel());
        check("frame_tick", frame_tick, expFt);
    endtask

    task automatic run(input int cycles);
        repeat (cycles) step();
    endtask

    task automatic runUntilSel(input int target);
        for (int k = 0; k < 2 * FRAME && modelSel() != target; k++) step();
        check("reach_sel", digit_sel, target);
    endtask

    initial begin
        logic [31:0] v;
        int          sig;
        reset     = 1'b1;
        modelSnap = 32'h0;
        setDigits(32'h0000_0525);

        // Reset, then $5.25 over two frames (scan timing and decode).
        doReset(3);
        run(2 * FRAME);

        // All zero: 0.00 with upper digits blanked.
        setDigits(32'h0000_0000);
        run(2 * FRAME);

        // Dash on digit 7, blank glyph on digit 1, embedded zeros shown.
        setDigits(32'hA000_00B0);
        run(2 * FRAME);

        // Tear-free: new value mid-frame must wait for the next snapshot.
        setDigits(32'h0000_0100);
        run(FRAME + 2);
        runUntilSel(3);
        setDigits(32'h0000_0999);
        run(FRAME + 4);

        // Mid-scan reset at digit 5, then a fresh scan with a new snapshot.
        runUntilSel(5);
        setDigits(32'h0000_1234);
        doReset(2);
        run(FRAME + 3);

        // Random values with a random number of significant digits.
        repeat (8) begin
            sig = $urandom_range(1, 8);
            v   = $urandom;
            if (sig < 8) v = v & ((32'h1 << (4 * sig)) - 32'h1);
            if ($urandom_range(0, 3) == 0) v[11:8] = 4'h0;
            setDigits(v);
            run(FRAME + $urandom_range(0, 12));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
